// File: rtl/uart_pkg.sv
// Shared UART constants: character width default, parity
// encodings and the error counter width.
package uart_pkg;

  parameter int DATA_BITS_DEF = 8;
  parameter int ERR_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-FIFO write strobe and consumer pop/read bundle.
// master = receiver plus consumer side, slave = the FIFO.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
);

  logic                 wr_valid;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_parity_error;
  logic                 rd_en;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_parity_error;
  logic                 rd_valid;

  modport master (
    output wr_valid,
    output wr_data,
    output wr_parity_error,
    output rd_en,
    input  rd_data,
    input  rd_parity_error,
    input  rd_valid
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_parity_error,
    input  rd_en,
    output rd_data,
    output rd_parity_error,
    output rd_valid
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read.
// Array itself is never reset so it maps onto block RAM.
module uart_fifo_mem #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Output register holds until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: stores {parity, data},
// tracks overflow and a saturating parity error count.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_BITS = DATA_BITS_DEF,
  parameter  int DEPTH     = 16,
  parameter  int DROP_BAD  = 0,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1,
  localparam int EW        = DATA_BITS + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_rx_fifo_if.slave            bus,
  input  logic                     clr_overflow,
  output logic                     empty,
  output logic                     full,
  output logic [CW-1:0]            count,
  output logic                     overflow,
  output logic [ERR_CNT_WIDTH-1:0] parity_err_count
);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, full_q;
  logic          ovf_q, ovf_d;
  logic          rv_q;
  logic [ERR_CNT_WIDTH-1:0] pec_q, pec_d;

  logic          pop, push, drop, lost;
  logic [EW-1:0] mem_rd;

  always_comb begin
    pop  = bus.rd_en && !empty_q;
    drop = (DROP_BAD != 0) && bus.wr_parity_error;
    // A full FIFO still accepts when the same cycle frees a slot.
    push = bus.wr_valid && !drop && (!full_q || pop);
    lost = bus.wr_valid && !drop && full_q && !pop;

    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);

    ovf_d = ovf_q;
    if (clr_overflow) ovf_d = 1'b0;
    if (lost)         ovf_d = 1'b1;

    pec_d = pec_q;
    if (bus.wr_valid && bus.wr_parity_error &&
        pec_q != {ERR_CNT_WIDTH{1'b1}}) begin
      pec_d = pec_q + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rv_q    <= 1'b0;
      pec_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CW'(DEPTH));
      ovf_q   <= ovf_d;
      rv_q    <= pop;
      pec_q   <= pec_d;
    end
  end

  uart_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i ({bus.wr_parity_error, bus.wr_data}),
    .re_i    (pop),
    .raddr_i (rptr_q),
    .rdata_o (mem_rd)
  );

  assign bus.rd_data         = mem_rd[DATA_BITS-1:0];
  assign bus.rd_parity_error = mem_rd[DATA_BITS];
  assign bus.rd_valid        = rv_q;

  assign empty            = empty_q;
  assign full             = full_q;
  assign count            = count_q;
  assign overflow         = ovf_q;
  assign parity_err_count = pec_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: dut0 keeps bad characters,
// dut1 drops them.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       wv  [2];
  logic [7:0] wd  [2];
  logic       wpe [2];
  logic       re  [2];
  logic       clr [2];

  logic       empty0, full0, ovf0;
  logic       empty1, full1, ovf1;
  logic [4:0] cnt0, cnt1;
  logic [7:0] pec0, pec1;

  uart_rx_fifo_if #(.DATA_BITS(8)) bus0 ();
  uart_rx_fifo_if #(.DATA_BITS(8)) bus1 ();

  assign bus0.wr_valid        = wv[0];
  assign bus0.wr_data         = wd[0];
  assign bus0.wr_parity_error = wpe[0];
  assign bus0.rd_en           = re[0];
  assign bus1.wr_valid        = wv[1];
  assign bus1.wr_data         = wd[1];
  assign bus1.wr_parity_error = wpe[1];
  assign bus1.rd_en           = re[1];

  uart_rx_fifo #(.DATA_BITS(8), .DEPTH(16), .DROP_BAD(0)) dut0 (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus0.slave),
    .clr_overflow     (clr[0]),
    .empty            (empty0),
    .full             (full0),
    .count            (cnt0),
    .overflow         (ovf0),
    .parity_err_count (pec0)
  );

  uart_rx_fifo #(.DATA_BITS(8), .DEPTH(16), .DROP_BAD(1)) dut1 (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus1.slave),
    .clr_overflow     (clr[1]),
    .empty            (empty1),
    .full             (full1),
    .count            (cnt1),
    .overflow         (ovf1),
    .parity_err_count (pec1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int         mcnt [2];
  logic       movf [2];
  int         mpec [2];
  logic       exp_rv;

  // Observed outputs of the selected DUT after a cycle
  logic       o_rv, o_rpe, o_empty, o_full, o_ovf;
  logic [7:0] o_rd, o_pec;
  logic [4:0] o_cnt;

  function automatic logic [8:0] qpop(input int s);
    if (s == 0) return (q0.size() > 0) ? q0.pop_front() : 9'bx;
    return (q1.size() > 0) ? q1.pop_front() : 9'bx;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0;
      movf[k] = 1'b0;
      mpec[k] = 0;
    end
  endtask

  task automatic cycle(input int s, input logic v, input logic [7:0] d,
                       input logic pe, input logic r, input logic c);
    logic fm, em, pp, dr, ps, ls;
    fm = (mcnt[s] == 16);
    em = (mcnt[s] == 0);
    pp = r && !em;
    dr = (s == 1) && pe;
    ps = v && !dr && (!fm || pp);
    ls = v && !dr && fm && !pp;
    if (ps) begin
      if (s == 0) q0.push_back({pe, d});
      else        q1.push_back({pe, d});
    end
    mcnt[s] = mcnt[s] + int'(ps) - int'(pp);
    exp_rv  = pp;
    if (c)  movf[s] = 1'b0;
    if (ls) movf[s] = 1'b1;
    if (v && pe && mpec[s] < 255) mpec[s]++;
    wv[s] = v; wd[s] = d; wpe[s] = pe; re[s] = r; clr[s] = c;
    @(posedge clk);
    #1;
    wv[s] = 1'b0; wd[s] = '0; wpe[s] = 1'b0; re[s] = 1'b0; clr[s] = 1'b0;
    if (s == 0) begin
      o_rv = bus0.rd_valid; o_rd = bus0.rd_data;
      o_rpe = bus0.rd_parity_error; o_empty = empty0;
      o_full = full0; o_ovf = ovf0; o_cnt = cnt0; o_pec = pec0;
    end else begin
      o_rv = bus1.rd_valid; o_rd = bus1.rd_data;
      o_rpe = bus1.rd_parity_error; o_empty = empty1;
      o_full = full1; o_ovf = ovf1; o_cnt = cnt1; o_pec = pec1;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    n_cmp++;
    if ({cnt0, empty0, full0, ovf0, pec0} !== {5'd0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_status0: got cnt=%0d e=%b f=%b o=%b p=%0d want 0 1 0 0 0",
               cnt0, empty0, full0, ovf0, pec0);
    end
    n_cmp++;
    if ({bus0.rd_valid, bus0.rd_data, bus0.rd_parity_error} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_rd0: got rv=%b rd=%h rpe=%b want 0 00 0",
               bus0.rd_valid, bus0.rd_data, bus0.rd_parity_error);
    end
    n_cmp++;
    if ({cnt1, empty1, full1, ovf1, pec1} !== {5'd0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_status1: got cnt=%0d e=%b want 0 1", cnt1, empty1);
    end
    model_reset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [8:0] e;
    cycle(0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    cycle(0, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    cycle(0, 1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (o_cnt !== 5'd3 || o_empty !== 1'b0) begin
      n_err++;
      $display("FAIL basic_count: got %0d e=%b want 3 e=0", o_cnt, o_empty);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (o_rv !== 1'b1) begin
        n_err++;
        $display("FAIL basic_rv%0d: got %b want 1", i, o_rv);
      end
      e = qpop(0);
      n_cmp++;
      if ({o_rpe, o_rd} !== e || o_rd !== 8'(8'h41 + i)) begin
        n_err++;
        $display("FAIL basic_data%0d: got %h want %h", i, {o_rpe, o_rd}, e);
      end
    end
    n_cmp++;
    if (o_empty !== 1'b1 || o_cnt !== 5'd0) begin
      n_err++;
      $display("FAIL basic_empty: got e=%b cnt=%0d want 1 0", o_empty, o_cnt);
    end
    // Pop while empty: ignored, last data held
    cycle(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (o_rv !== 1'b0 || o_rd !== 8'h43 || o_cnt !== 5'd0) begin
      n_err++;
      $display("FAIL empty_pop: got rv=%b rd=%h cnt=%0d want 0 43 0",
               o_rv, o_rd, o_cnt);
    end
    // Write and pop on empty: write only, no bypass
    cycle(0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (o_rv !== exp_rv || o_rv !== 1'b0 || o_cnt !== 5'd1) begin
      n_err++;
      $display("FAIL empty_wr_pop: got rv=%b cnt=%0d want 0 1", o_rv, o_cnt);
    end
    cycle(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    e = qpop(0);
    n_cmp++;
    if (o_rv !== 1'b1 || {o_rpe, o_rd} !== e) begin
      n_err++;
      $display("FAIL empty_wr_pop_data: got rv=%b %h want 1 %h",
               o_rv, {o_rpe, o_rd}, e);
    end
  endtask

  task automatic test_overflow();
    logic [8:0] e;
    for (int i = 0; i < 17; i++) begin
      cycle(0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 15) begin
        n_cmp++;
        if (o_full !== 1'b1 || o_cnt !== 5'd16 || o_ovf !== 1'b0) begin
          n_err++;
          $display("FAIL ovf_fill: got f=%b cnt=%0d o=%b want 1 16 0",
                   o_full, o_cnt, o_ovf);
        end
      end
    end
    n_cmp++;
    if (o_ovf !== 1'b1 || o_cnt !== 5'd16 || o_full !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set: got o=%b cnt=%0d f=%b want 1 16 1",
               o_ovf, o_cnt, o_full);
    end
    cycle(0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (o_ovf !== movf[0] || o_ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set_wins: got %b want 1", o_ovf);
    end
    cycle(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (o_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: got %b want 0", o_ovf);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      e = qpop(0);
      n_cmp++;
      if (o_rv !== 1'b1 || {o_rpe, o_rd} !== e || o_rd !== 8'(i)) begin
        n_err++;
        $display("FAIL ovf_drain%0d: got rv=%b %h want 1 %h",
                 i, o_rv, {o_rpe, o_rd}, e);
      end
    end
    n_cmp++;
    if (o_empty !== 1'b1 || o_full !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_empty: got e=%b f=%b want 1 0", o_empty, o_full);
    end
  endtask

  task automatic test_full_simul();
    logic [8:0] e;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    end
    cycle(0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    e = qpop(0);
    n_cmp++;
    if (o_rv !== 1'b1 || {o_rpe, o_rd} !== e) begin
      n_err++;
      $display("FAIL full_simul_pop: got rv=%b %h want 1 %h",
               o_rv, {o_rpe, o_rd}, e);
    end
    n_cmp++;
    if (o_cnt !== 5'd16 || o_ovf !== 1'b0 || o_full !== 1'b1) begin
      n_err++;
      $display("FAIL full_simul_status: got cnt=%0d o=%b f=%b want 16 0 1",
               o_cnt, o_ovf, o_full);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      e = qpop(0);
      n_cmp++;
      if (o_rv !== 1'b1 || {o_rpe, o_rd} !== e) begin
        n_err++;
        $display("FAIL full_simul_drain%0d: got %h want %h",
                 i, {o_rpe, o_rd}, e);
      end
    end
    n_cmp++;
    if (o_rd !== 8'hAA || o_empty !== 1'b1) begin
      n_err++;
      $display("FAIL full_simul_last: got %h e=%b want aa 1", o_rd, o_empty);
    end
  endtask

  task automatic test_drop_bad();
    logic [8:0] e;
    cycle(1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    cycle(1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (o_pec !== 8'd1 || o_cnt !== 5'd1) begin
      n_err++;
      $display("FAIL drop_status: got pec=%0d cnt=%0d want 1 1", o_pec, o_cnt);
    end
    cycle(1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    e = qpop(1);
    n_cmp++;
    if (o_rv !== 1'b1 || {o_rpe, o_rd} !== e || {o_rpe, o_rd} !== 9'h066) begin
      n_err++;
      $display("FAIL drop_data: got rv=%b %h want 1 %h", o_rv, {o_rpe, o_rd}, e);
    end
  endtask

  task automatic test_parity_sat();
    logic [8:0] e;
    for (int i = 0; i < 300; i++) begin
      cycle(0, 1'b1, 8'(i), 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (o_rv !== exp_rv) begin
        n_err++;
        $display("FAIL sat_rv%0d: got %b want %b", i, o_rv, exp_rv);
      end
      if (exp_rv) begin
        e = qpop(0);
        n_cmp++;
        if ({o_rpe, o_rd} !== e) begin
          n_err++;
          $display("FAIL sat_data%0d: got %h want %h", i, {o_rpe, o_rd}, e);
        end
      end
    end
    n_cmp++;
    if (o_pec !== 8'd255 || o_cnt !== 5'(mcnt[0])) begin
      n_err++;
      $display("FAIL sat_count: got pec=%0d cnt=%0d want 255 %0d",
               o_pec, o_cnt, mcnt[0]);
    end
    cycle(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    e = qpop(0);
    n_cmp++;
    if (o_rv !== 1'b1 || {o_rpe, o_rd} !== e || o_rpe !== 1'b1) begin
      n_err++;
      $display("FAIL sat_last: got %h want %h", {o_rpe, o_rd}, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] e;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    end
    wv[0] = 1'b1;
    wd[0] = 8'h99;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (cnt0 !== 5'd0 || empty0 !== 1'b1 || pec0 !== 8'd0) begin
      n_err++;
      $display("FAIL mid_reset_async: got cnt=%0d e=%b pec=%0d want 0 1 0",
               cnt0, empty0, pec0);
    end
    wv[0] = 1'b0;
    wd[0] = '0;
    model_reset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(0, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (o_cnt !== 5'd1) begin
      n_err++;
      $display("FAIL mid_reset_count: got %0d want 1", o_cnt);
    end
    cycle(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    e = qpop(0);
    n_cmp++;
    if (o_rv !== 1'b1 || {o_rpe, o_rd} !== e || o_rd !== 8'h7E) begin
      n_err++;
      $display("FAIL mid_reset_data: got rv=%b %h want 1 07e", o_rv, {o_rpe, o_rd});
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      wv[k] = 1'b0; wd[k] = '0; wpe[k] = 1'b0; re[k] = 1'b0; clr[k] = 1'b0;
    end
    model_reset();
    test_reset();
    test_basic();
    test_overflow();
    test_full_simul();
    test_drop_bad();
    test_parity_sat();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8, received character width.
REQ-002 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of 2, minimum 2.
REQ-003 Parameter DROP_BAD, default 0; 1 = characters flagged with a parity error are counted but not stored.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port wr_valid, input, 1 bit: one-cycle strobe from the receiver marking a completed character.
REQ-007 Port wr_data, input, DATA_BITS bits: received character, valid while wr_valid=1.
REQ-008 Port wr_parity_error, input, 1 bit: parity error for that character, valid while wr_valid=1.
REQ-009 Port rd_en, input, 1 bit: consumer pop request.
REQ-010 Port clr_overflow, input, 1 bit: clears the overflow flag.
REQ-011 Port rd_data, output, DATA_BITS bits: registered popped character.
REQ-012 Port rd_parity_error, output, 1 bit: stored parity flag of the popped character.
REQ-013 Port rd_valid, output, 1 bit: one-cycle strobe marking rd_data/rd_parity_error as updated.
REQ-014 Ports empty and full, outputs, 1 bit each: FIFO status.
REQ-015 Port count, output, clog2(DEPTH)+1 bits: current occupancy, range 0..DEPTH.
REQ-016 Port overflow, output, 1 bit: sticky flag, a character was lost.
REQ-017 Port parity_err_count, output, 8 bits: saturating count of characters received with wr_parity_error=1.

Function
REQ-018 Each entry SHALL store {parity flag, data}, DATA_BITS+1 bits wide.
REQ-019 A write SHALL be accepted when wr_valid=1, the FIFO is not full, and not (DROP_BAD=1 and wr_parity_error=1); it is stored at the write pointer and the write pointer advances.
REQ-020 A pop SHALL occur when rd_en=1 and empty=0; rd_data, rd_parity_error and rd_valid=1 appear the following cycle, giving a latency of 1.
REQ-021 rd_en while empty SHALL be ignored: no pointer change, rd_valid=0, and rd_data holds its previous value.
REQ-022 rd_data and rd_parity_error SHALL hold their last value until the next pop.
REQ-023 With a write and a pop in the same cycle and 0<count<DEPTH, both SHALL occur and count is unchanged.
REQ-024 When full, a simultaneous write and pop SHALL both succeed; the write lands in the slot freed by the pop and count stays at DEPTH.
REQ-025 When empty, a simultaneous write and pop SHALL accept the write only; there is no bypass, and count becomes 1.
REQ-026 When full, wr_valid without a pop SHALL discard the character, leave count unchanged, and set overflow=1 on the next cycle.
REQ-027 overflow SHALL remain set until clr_overflow=1; if clr_overflow and a new overflow event coincide, set wins.
REQ-028 parity_err_count SHALL increment on every wr_valid with wr_parity_error=1, whether the character is stored, dropped or lost, and SHALL saturate at 255.
REQ-029 Pointers are clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0; full and empty SHALL be derived from count, not from pointer equality alone.
REQ-030 empty, full and count SHALL be registered and consistent in the cycle after any accepted operation.
REQ-031 There is no state machine beyond the pointers and counters; all control is single-cycle.

Reset
REQ-032 rst=0 SHALL immediately clear both pointers, count=0, empty=1, full=0, overflow=0, parity_err_count=0, rd_valid=0, rd_data=0 and rd_parity_error=0.
REQ-033 Storage array contents SHALL NOT be reset.
REQ-034 Reset asserted mid-operation SHALL discard all stored characters; the first write after release is read back first.

Structure
REQ-035 The shared package uart_pkg SHALL hold the DATA_BITS default, the parity-type encodings (0 none, 1 odd, 2 even) and the ERR_CNT_WIDTH=8 constant.
REQ-036 Storage SHALL be the sub-module uart_fifo_mem: a simple dual-port array with one synchronous write port and one registered read port, inferable as block RAM.

Verification
REQ-037 Write 0x41, 0x42, 0x43, then pop 3 times -> rd_data 0x41, 0x42, 0x43 each one cycle after rd_en, rd_valid pulsed 3 times, empty=1 at the end.
REQ-038 Write 17 characters 0x00..0x10 with DEPTH=16 -> full=1 after 16, overflow=1, count=16; popping all returns 0x00..0x0F.
REQ-039 Full FIFO, simultaneous wr_valid (0xAA) and rd_en -> count stays 16, overflow=0; 0xAA is popped last.
REQ-040 DROP_BAD=1, write 0x55 with wr_parity_error=1, then 0x66 clean -> parity_err_count=1, count=1, pop returns 0x66 with rd_parity_error=0.
REQ-041 Write 300 characters with parity error while popping continuously -> parity_err_count=255 (saturated).
REQ-042 Write 5 characters, assert rst=0 mid-write, release, write 0x7E -> count=1, and a pop returns 0x7E.
